// File: rtl/hex_scan_controller.sv
// Four-digit hex display scanner sharing one external hex decoder; one digit latched per divider tick.
// Optional leading-zero blanking is compiled in when HEX_SCAN_LZB_EN is defined.
module hex_scan_controller #(
  parameter int unsigned DIV_MAX   = 49999,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  dec_nibble,
  input  logic [6:0]  dec_seg,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX);
  localparam logic [6:0]           SEG_OFF  = 7'h7F;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [15:0]           shadow_q, shadow_d;
  logic [3:0][6:0]       hex_q, hex_d;

  logic                  tick;
  logic [6:0]            seg_lat;

  assign tick = (state_q == SCAN) && (div_q == DIV_LAST);

`ifdef HEX_SCAN_LZB_EN
  // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
  logic blank;
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = (shadow_q[15:4]  == 12'h000);
      2'd2:    blank = (shadow_q[15:8]  == 8'h00);
      2'd3:    blank = (shadow_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
  assign seg_lat = blank ? SEG_OFF : dec_seg;
`else
  assign seg_lat = dec_seg;
`endif

  always_comb begin
    dec_nibble = 4'h0;
    if (state_q == SCAN) begin
      dec_nibble = shadow_q[{idx_q, 2'b00} +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    hex_d    = hex_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shadow_d = value;
          idx_d    = 2'd0;
          div_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          hex_d[idx_q] = seg_lat;
          idx_d        = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      div_q    <= '0;
      shadow_q <= 16'h0000;
      hex_q    <= {4{SEG_OFF}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_hex_scan_controller.sv
// Bench for hex_scan_controller: DIV_MAX=3 and DIV_MAX=0 instances, each fed by an active-low hex decoder model.
module tb_hex_scan_controller;

`ifdef HEX_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        load_a = 1'b0;
  logic [15:0] value_a = 16'h0;
  logic [3:0]  nib_a;
  logic [6:0]  seg_a;
  logic [6:0]  hex0_a, hex1_a, hex2_a, hex3_a;
  logic        busy_a, done_a;

  logic        load_b = 1'b0;
  logic [15:0] value_b = 16'h0;
  logic [3:0]  nib_b;
  logic [6:0]  seg_b;
  logic [6:0]  hex0_b, hex1_b, hex2_b, hex3_b;
  logic        busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] exp_hex [4];

  always #5 clock = ~clock;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic logic [6:0] exp_digit(input logic [15:0] v, input int i);
    if (LZB && i > 0 && (v >> (4 * i)) == 16'h0) return 7'h7F;
    return seg7(v[4*i +: 4]);
  endfunction

  assign seg_a = seg7(nib_a);
  assign seg_b = seg7(nib_b);

  hex_scan_controller #(.DIV_MAX(3), .DIV_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .load(load_a), .value(value_a),
    .dec_nibble(nib_a), .dec_seg(seg_a),
    .hex0(hex0_a), .hex1(hex1_a), .hex2(hex2_a), .hex3(hex3_a),
    .busy(busy_a), .done(done_a)
  );

  hex_scan_controller #(.DIV_MAX(0), .DIV_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .load(load_b), .value(value_b),
    .dec_nibble(nib_b), .dec_seg(seg_b),
    .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b), .hex3(hex3_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hex_a(input string tag);
    chk({tag, "_hex0"}, {25'd0, hex0_a}, {25'd0, exp_hex[0]});
    chk({tag, "_hex1"}, {25'd0, hex1_a}, {25'd0, exp_hex[1]});
    chk({tag, "_hex2"}, {25'd0, hex2_a}, {25'd0, exp_hex[2]});
    chk({tag, "_hex3"}, {25'd0, hex3_a}, {25'd0, exp_hex[3]});
  endtask

  // Full scan on dut_a (tick period 4): nibble order, busy window, done timing, final digits.
  task automatic scan_a(input logic [15:0] v, input bit inject, input logic [15:0] junk);
    int done_cycle;
    done_cycle = -1;
    @(negedge clock);
    load_a  = 1'b1;
    value_a = v;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done_a) begin
        done_cycle = c;
        chk("busy_in_done", {31'd0, busy_a}, 32'd0);
        break;
      end
      if (c <= 16) begin
        chk("busy_scan", {31'd0, busy_a}, 32'd1);
        chk("nibble", {28'd0, nib_a}, {28'd0, v[4*((c-1)/4) +: 4]});
      end
      load_a  = (inject && c == 5) ? 1'b1 : 1'b0;
      value_a = (inject && c == 5) ? junk : 16'h0;
    end
    load_a = 1'b0;
    chk("done_cycle", done_cycle, 32'd17);
    @(negedge clock);
    chk("done_pulse_end", {31'd0, done_a}, 32'd0);
    chk("busy_idle", {31'd0, busy_a}, 32'd0);
    chk("nibble_idle", {28'd0, nib_a}, 32'd0);
    chk("shadow", {16'd0, dut_a.shadow_q}, {16'd0, v});
    for (int i = 0; i < 4; i++) exp_hex[i] = exp_digit(v, i);
    chk_hex_a("scan");
  endtask

  initial begin
    int dcount;
    int dcyc;
    logic [15:0] rv;
    for (int i = 0; i < 4; i++) exp_hex[i] = 7'h7F;

    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_hex_a("reset");
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_done", {31'd0, done_a}, 32'd0);
    chk("reset_nib", {28'd0, nib_a}, 32'd0);
    chk("reset_shadow", {16'd0, dut_a.shadow_q}, 32'd0);

    scan_a(16'h1234, 1'b0, 16'h0);
    scan_a(16'h5678, 1'b1, 16'hBEEF);
    scan_a(16'h0007, 1'b0, 16'h0);
    scan_a(16'h0000, 1'b0, 16'h0);
    scan_a(16'h00A0, 1'b0, 16'h0);

    for (int k = 0; k < 6; k++) begin
      rv = 16'($urandom);
      if (k == 1) rv = rv & 16'h00FF;
      repeat ($urandom_range(3, 0)) @(negedge clock);
      scan_a(rv, 1'($urandom_range(1, 0)), 16'($urandom));
    end

    repeat (10) @(negedge clock);
    chk_hex_a("idle_hold");

    // Abort a scan with reset during cycle 6.
    @(negedge clock);
    load_a  = 1'b1;
    value_a = 16'h9ABC;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      load_a = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_hex[i] = 7'h7F;
    chk_hex_a("abort");
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (done_a) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);
    chk_hex_a("abort_hold");

    // Reset wins over a simultaneous load.
    @(negedge clock);
    reset   = 1'b1;
    load_a  = 1'b1;
    value_a = 16'hC3A5;
    @(negedge clock);
    reset  = 1'b0;
    load_a = 1'b0;
    chk("rst_load_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_load_shadow", {16'd0, dut_a.shadow_q}, 32'd0);
    @(negedge clock);
    chk("rst_load_busy2", {31'd0, busy_a}, 32'd0);

    // Divider of 0 ticks every cycle.
    @(negedge clock);
    load_b  = 1'b1;
    value_b = 16'hFFFF;
    dcyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      load_b = 1'b0;
      if (done_b) begin
        dcyc = c;
        break;
      end
      if (c <= 4) chk("b_busy", {31'd0, busy_b}, 32'd1);
    end
    chk("b_done_cycle", dcyc, 32'd5);
    chk("b_hex0", {25'd0, hex0_b}, 32'h0E);
    chk("b_hex1", {25'd0, hex1_b}, 32'h0E);
    chk("b_hex2", {25'd0, hex2_b}, 32'h0E);
    chk("b_hex3", {25'd0, hex3_b}, 32'h0E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
